// File: rtl/ft600_mode245.sv
// ft600_mode245 -- bridge between user logic and an FT600 in 245 synchronous
// FIFO mode (16-bit bus).
//
// User side:
//   tx_en/tx_in  push a word into the TX FIFO; tx_full flags a full TX FIFO.
//   rx_en        pops the RX FIFO head; rx_out shows that head (first-word
//                fall-through) while rx_empty is low.
// FT600 side:
//   ft_txe/ft_rxf  active-low "can accept write" / "has read data".
//   ft_oe/ft_rd/ft_wr  active-low bus enable and strobes.
//   ft_data/ft_be  driven by this block only while writing, high-Z otherwise.
//   ft_clk is present for pin compatibility only; clk must come from the same
//   source.

// Synchronous FIFO with fall-through output and a W+1 bit occupancy count.
module ft600_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [15:0]  din_i,
   input  logic         pop_i,
   output logic [15:0]  dout_o,
   output logic [W:0]   cnt_o,
   output logic         full_o,
   output logic         empty_o
);
   logic [15:0]  mem_q [2**W];
   logic [W-1:0] wr_ptr_q, rd_ptr_q;
   logic [W:0]   cnt_q;
   logic         push_ok, pop_ok;

   // Count never exceeds 2^W, so its MSB alone marks full.
   assign full_o  = cnt_q[W];
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end
endmodule

module ft600_mode245 #(
   parameter int RX_BUF_WIDTH = 8,
   parameter int TX_BUF_WIDTH = 8
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        tx_en,
   input  logic [15:0] tx_in,
   output logic        tx_full,
   input  logic        rx_en,
   output logic [15:0] rx_out,
   output logic        rx_empty,
   input  logic        ft_clk,
   inout  wire  [15:0] ft_data,
   inout  wire  [1:0]  ft_be,
   input  logic        ft_txe,
   input  logic        ft_rxf,
   output logic        ft_oe,
   output logic        ft_rd,
   output logic        ft_wr
);
   typedef enum logic [1:0] {IDLE, RX_OE, RX, TX} state_t;

   localparam logic [RX_BUF_WIDTH:0] RX_LAST = (RX_BUF_WIDTH+1)'(2**RX_BUF_WIDTH - 1);
   localparam logic [TX_BUF_WIDTH:0] TX_ONE  = (TX_BUF_WIDTH+1)'(1);

   state_t state_q, state_d;
   logic   last_rx_q, last_rx_d;   // 1: RX was served last, 0: TX

   logic [15:0]             tx_head;
   logic [TX_BUF_WIDTH:0]   tx_cnt;
   logic [RX_BUF_WIDTH:0]   rx_cnt;
   logic                    tx_empty, rx_full;
   logic                    rx_push, tx_pop;
   logic                    rd_pend, wr_pend, rx_fills, tx_drains;

   ft600_fifo #(.W(TX_BUF_WIDTH)) u_tx (
      .clk(clk), .rst(rst),
      .push_i(tx_en), .din_i(tx_in), .pop_i(tx_pop),
      .dout_o(tx_head), .cnt_o(tx_cnt), .full_o(tx_full), .empty_o(tx_empty)
   );

   ft600_fifo #(.W(RX_BUF_WIDTH)) u_rx (
      .clk(clk), .rst(rst),
      .push_i(rx_push), .din_i(ft_data), .pop_i(rx_en),
      .dout_o(rx_out), .cnt_o(rx_cnt), .full_o(rx_full), .empty_o(rx_empty)
   );

   // A strobe is only low while its FIFO can take/give a word, so the
   // transfer condition reduces to state, FIFO level and the FT600 flag.
   assign rx_push = (state_q == RX) & ~rx_full & ~ft_rxf;
   assign tx_pop  = (state_q == TX) & ~tx_empty & ~ft_txe;

   assign rd_pend = ~ft_rxf & ~rx_full;
   assign wr_pend = ~ft_txe & ~tx_empty;

   // Level after this edge, accounting for a concurrent user pop/push.
   assign rx_fills  = rx_push & ~(rx_en & ~rx_empty) & (rx_cnt == RX_LAST);
   assign tx_drains = tx_pop & ~(tx_en & ~tx_full) & (tx_cnt == TX_ONE);

   assign ft_data = (state_q == TX) ? tx_head : 16'bz;
   assign ft_be   = (state_q == TX) ? 2'b11   : 2'bzz;

   // Read byte enables carry no information; clock is the shared clk.
   logic unused_ok;
   assign unused_ok = ^{ft_clk, ft_be};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_rx_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_rx_q <= last_rx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_rx_d = last_rx_q;
      ft_oe     = 1'b1;
      ft_rd     = 1'b1;
      ft_wr     = 1'b1;
      case (state_q)
         IDLE: begin
            // On a tie, alternate: serve RX unless RX went last.
            if (rd_pend && (!wr_pend || !last_rx_q)) begin
               state_d   = RX_OE;
               last_rx_d = 1'b1;
            end else if (wr_pend) begin
               state_d   = TX;
               last_rx_d = 1'b0;
            end
         end
         RX_OE: begin
            ft_oe   = 1'b0;
            state_d = RX;
         end
         RX: begin
            ft_oe = 1'b0;
            ft_rd = rx_full;
            if (ft_rxf || rx_full || rx_fills) state_d = IDLE;
         end
         TX: begin
            ft_wr = tx_empty;
            if (ft_txe || tx_empty || tx_drains) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ft600_mode245.sv
// Directed bench for ft600_mode245 with both FIFOs 4 deep. A host model
// serves reads from an array (driving the bus while ft_oe is low) and
// records every word written. Undriven bus lines are pulled low.
module tb_ft600_mode245;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_en = 1'b0;
   logic [15:0] tx_in = '0;
   logic        tx_full;
   logic        rx_en = 1'b0;
   logic [15:0] rx_out;
   logic        rx_empty;
   wire  [15:0] ft_data;
   wire  [1:0]  ft_be;
   logic        ft_txe = 1'b1;
   logic        ft_rxf;
   logic        ft_oe, ft_rd, ft_wr;

   always #5 clk = ~clk;

   ft600_mode245 #(.RX_BUF_WIDTH(2), .TX_BUF_WIDTH(2)) dut (
      .rst(rst), .clk(clk), .tx_en(tx_en), .tx_in(tx_in), .tx_full(tx_full),
      .rx_en(rx_en), .rx_out(rx_out), .rx_empty(rx_empty), .ft_clk(clk),
      .ft_data(ft_data), .ft_be(ft_be), .ft_txe(ft_txe), .ft_rxf(ft_rxf),
      .ft_oe(ft_oe), .ft_rd(ft_rd), .ft_wr(ft_wr)
   );

   pulldown pd_data (ft_data);
   pulldown pd_be (ft_be);

   // Host read source
   logic [15:0] hq [0:63];
   int          hq_n = 0;
   int          hq_idx = 0;
   logic        rxf_off = 1'b1;
   logic        host_flush = 1'b0;
   logic [15:0] host_word;

   assign host_word = hq[hq_idx[5:0]];
   assign ft_rxf    = rxf_off | (hq_idx >= hq_n);
   assign ft_data   = !ft_oe ? host_word : 16'bz;

   always @(posedge clk) begin
      if (host_flush) hq_idx <= hq_n;
      else if (!ft_rd && !ft_rxf) hq_idx <= hq_idx + 1;
   end

   // Host write sink
   logic [15:0] sk [0:63];
   int          sk_n = 0;

   always @(posedge clk) begin
      if (!ft_wr && !ft_txe) begin
         sk[sk_n[5:0]] <= ft_data;
         sk_n          <= sk_n + 1;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic host_add(input logic [15:0] w);
      hq[hq_n[5:0]] = w;
      hq_n++;
   endtask

   int sbase, hbase;

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_tx_full", tx_full, 0);
      chk("rst_rx_empty", rx_empty, 1);
      chk("rst_oe", ft_oe, 1);
      chk("rst_rd", ft_rd, 1);
      chk("rst_wr", ft_wr, 1);
      chk("rst_data_z", ft_data, 16'h0000);
      chk("rst_be_z", ft_be, 2'b00);

      // TX loopback: three words back to back
      ft_txe = 1'b0;
      sbase  = sk_n;
      tx_en = 1'b1; tx_in = 16'h0000; tick();
      tx_in = 16'h0101; tick();
      chk("lb_wr0", ft_wr, 0);
      chk("lb_d0", ft_data, 16'h0000);
      chk("lb_be0", ft_be, 2'b11);
      tx_in = 16'h0202; tick();
      chk("lb_wr1", ft_wr, 0);
      chk("lb_d1", ft_data, 16'h0101);
      tx_en = 1'b0; tick();
      chk("lb_wr2", ft_wr, 0);
      chk("lb_d2", ft_data, 16'h0202);
      tick();
      chk("lb_wr_end", ft_wr, 1);
      chk("lb_data_z", ft_data, 16'h0000);
      chk("lb_be_z", ft_be, 2'b00);
      chk("lb_count", sk_n - sbase, 3);

      // RX burst
      host_add(16'h0102); host_add(16'h0203); host_add(16'h0304);
      rxf_off = 1'b0;
      tick();
      chk("rx_oe_first", ft_oe, 0);
      chk("rx_rd_late", ft_rd, 1);
      tick();
      chk("rx_rd_low", ft_rd, 0);
      chk("rx_bus", ft_data, 16'h0102);
      repeat (4) tick();
      chk("rx_oe_end", ft_oe, 1);
      chk("rx_rd_end", ft_rd, 1);
      chk("rx_nonempty", rx_empty, 0);
      chk("rx_w0", rx_out, 16'h0102);
      rx_en = 1'b1; tick();
      chk("rx_w1", rx_out, 16'h0203);
      tick();
      chk("rx_w2", rx_out, 16'h0304);
      tick();
      rx_en = 1'b0;
      chk("rx_empty_end", rx_empty, 1);

      // TX full and backpressure
      ft_txe = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tx_en = 1'b1; tx_in = 16'hA001 + 16'(i); tick();
         if (i == 2) chk("txf_3", tx_full, 0);
         if (i >= 3) chk("txf_full", tx_full, 1);
      end
      tx_en  = 1'b0;
      sbase  = sk_n;
      ft_txe = 1'b0;
      tick();
      chk("txf_wr", ft_wr, 0);
      chk("txf_head", ft_data, 16'hA001);
      chk("txf_still_full", tx_full, 1);
      tick();
      chk("txf_released", tx_full, 0);
      repeat (6) tick();
      chk("txf_sent", sk_n - sbase, 4);
      for (int k = 0; k < 4; k++)
         chk("txf_word", sk[sbase + k], 16'hA001 + 16'(k));
      chk("txf_wr_end", ft_wr, 1);

      // RX full: host offers 10, only 4 fit
      hbase = hq_n;
      for (int i = 0; i < 10; i++) host_add(16'hB000 + 16'(i));
      repeat (12) tick();
      chk("rxf_captured", hq_idx - hbase, 4);
      chk("rxf_rd_high", ft_rd, 1);
      chk("rxf_oe_high", ft_oe, 1);
      rxf_off = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("rxf_word", rx_out, 16'hB000 + 16'(k));
         rx_en = 1'b1; tick();
      end
      rx_en = 1'b0;
      chk("rxf_empty", rx_empty, 1);
      host_flush = 1'b1; tick();
      host_flush = 1'b0;

      // Reset mid TX burst
      ft_txe = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tx_en = 1'b1; tx_in = 16'hC001 + 16'(i); tick();
      end
      tx_en = 1'b0;
      chk("mr_full", tx_full, 1);
      ft_txe = 1'b0; tick();
      chk("mr_wr", ft_wr, 0);
      chk("mr_d0", ft_data, 16'hC001);
      tick();
      chk("mr_d1", ft_data, 16'hC002);
      rst = 1'b1; tick();
      chk("mr_wr_high", ft_wr, 1);
      chk("mr_oe_high", ft_oe, 1);
      chk("mr_rd_high", ft_rd, 1);
      chk("mr_tx_full", tx_full, 0);
      chk("mr_rx_empty", rx_empty, 1);
      chk("mr_data_z", ft_data, 16'h0000);
      chk("mr_be_z", ft_be, 2'b00);
      sbase = sk_n;
      rst = 1'b0;
      repeat (6) tick();
      chk("mr_no_more", sk_n - sbase, 0);
      chk("mr_wr_idle", ft_wr, 1);

      // Arbitration tie (RX first after reset), then txe throttle
      ft_txe = 1'b1;
      tx_en = 1'b1; tx_in = 16'hD001; tick();
      tx_in = 16'hD002; tick();
      tx_en = 1'b0;
      host_add(16'hE001); host_add(16'hE002);
      rxf_off = 1'b0;
      ft_txe  = 1'b0;
      sbase   = sk_n;
      tick();
      chk("arb_rx_first", ft_oe, 0);
      chk("arb_no_wr", ft_wr, 1);
      tick();
      chk("arb_rd", ft_rd, 0);
      repeat (3) tick();
      chk("arb_idle_oe", ft_oe, 1);
      chk("arb_idle_rd", ft_rd, 1);
      chk("arb_idle_wr", ft_wr, 1);
      chk("arb_idle_bus", ft_data, 16'h0000);
      tick();
      chk("arb_tx_wr", ft_wr, 0);
      chk("arb_tx_d0", ft_data, 16'hD001);
      ft_txe = 1'b1; tick();
      chk("thr_wr_high", ft_wr, 1);
      chk("thr_no_pop", sk_n - sbase, 0);
      ft_txe = 1'b0; tick();
      chk("thr_wr_again", ft_wr, 0);
      chk("thr_d0_again", ft_data, 16'hD001);
      tick();
      chk("thr_d1", ft_data, 16'hD002);
      repeat (2) tick();
      chk("thr_sent", sk_n - sbase, 2);
      chk("thr_w0", sk[sbase], 16'hD001);
      chk("thr_w1", sk[sbase + 1], 16'hD002);
      chk("thr_wr_end", ft_wr, 1);
      chk("arb_rx_w0", rx_out, 16'hE001);
      rx_en = 1'b1; tick();
      chk("arb_rx_w1", rx_out, 16'hE002);
      tick();
      rx_en = 1'b0;
      chk("arb_rx_empty", rx_empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
